bram_sqp_arb: RTL and testbench
===============================

Name: bram_sqp_arb

Overview:
- Round-robin arbiter that shares a simple quadruple-port BRAM among REQS requesters.
- The BRAM has two port pairs; each pair has one write address and one read address.
- Each cycle the arbiter grants up to two requesters, one per port pair, and returns read data to the originating requester with a fixed latency.
- Sits between several pixel and sprite engines and one shared on-chip buffer.

Parameters:
- REQS, 4, number of requesters; legal range 2..8.
- WIDTH, 8, data width in bits.
- DEPTH, 256, memory depth in words; AW = $clog2(DEPTH).

Ports:
- clk  in  1  common clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  REQS  per-requester request; held until granted.
- we  in  REQS  per-requester op: 1 = write, 0 = read.
- addr  in  REQS*AW  flattened addresses; requester i uses slice [i*AW +: AW].
- din  in  REQS*WIDTH  flattened write data.
- gnt  out  REQS  combinational grant for the current cycle.
- rvalid  out  REQS  one-cycle read-return strobe.
- rdata  out  REQS*WIDTH  registered per-requester read data.
- mem_we0, mem_we1  out  1  BRAM write enables.
- mem_addr_write0, mem_addr_write1  out  AW  BRAM write addresses.
- mem_addr_read0, mem_addr_read1  out  AW  BRAM read addresses.
- mem_din0, mem_din1  out  WIDTH  BRAM write data.
- mem_dout0, mem_dout1  in  WIDTH  BRAM read data; 1-cycle registered.

Behaviour:
- Reset values:
  - ptr = 0.
  - rvalid = 0, rdata = 0.
  - Pipeline valid/tag registers = 0.
  - gnt and mem_we* are 0 while rst_n is low.
- Grant selection (combinational, one cycle):
  - Scan indices ptr, ptr+1, …, wrapping mod REQS.
  - The first requester with req=1 is granted on port 0.
  - Continue the scan; the next requester with req=1 that does not conflict is granted on port 1.
  - Conflict: same address as the port-0 grant, and at least one of the two ops is a write.
  - A conflicting requester is skipped this cycle, not dropped; it keeps req high.
  - Two reads to the same address do not conflict.
- Port drive:
  - The granted requester's addr drives both mem_addr_write and mem_addr_read of its port.
  - mem_din = granted din.
  - mem_we = granted we.
  - An unused port has mem_we=0; its addresses and data are don't-care.
- Pointer update:
  - If any grant is issued, ptr <= (index of last grant issued this cycle + 1) mod REQS.
  - Otherwise ptr holds.
  - A requester is guaranteed service within REQS-1 cycles of the others' grants (no starvation).
- Handshake:
  - gnt[i] high means the transaction is accepted that cycle.
  - The requester may change req, we, addr and din on the next edge.
  - gnt depends combinationally on req, we and addr. Requesters must not derive req from gnt in the same cycle.
- Read return, for a read granted in cycle N:
  - N+1: mem_dout of that port is sampled.
  - N+2: rdata[i] holds the value and rvalid[i]=1 for exactly one cycle.
  - rdata[i] holds that value until the next read return to requester i.
- Throughput: up to 2 transactions per cycle; back-to-back reads from one requester return in order, one per cycle.
- A write in cycle N is visible to a read granted in cycle N+1 or later.
- Reset mid-operation: in-flight reads are discarded; no rvalid is issued for any read granted before reset deassertion.

Test Plan:
- Single requester: req[0]=1, we=1, addr=0x10, din=0xA5, then a read of 0x10 → gnt[0] in both cycles; rvalid[0] two cycles after the read grant with rdata[0]=0xA5.
- All four requesting reads of distinct addresses every cycle, ptr=0 → cycle 1 grants {0,1}, cycle 2 {2,3}, cycle 3 {0,1}; each rvalid arrives exactly 2 cycles after its grant.
- req[1] write 0x20 and req[2] read 0x20 in the same cycle, ptr=1 → only gnt[1] that cycle; gnt[2] next cycle, with returned data equal to the written value.
- req[0] and req[3] both read 0x05, which holds 0x3C → both granted in one cycle; rvalid[0] and rvalid[3] together, both rdata=0x3C.
- Reads granted, rst_n pulsed low for one cycle before return → no rvalid; rdata=0; ptr=0; next grant starts at requester 0.
- req[3] held high while 0–2 requests continuously → gnt[3] within 2 cycles of first assertion (no starvation).

Source files
------------

// File: rtl/bram_sqp_arb.sv
// rtl/bram_sqp_arb.sv - round-robin arbiter sharing a dual write/read port-pair BRAM among requesters
module bram_sqp_arb #(
    parameter int REQS  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = $clog2(REQS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REQS-1:0]         req,
    input  logic [REQS-1:0]         we,
    input  logic [REQS*AW-1:0]      addr,
    input  logic [REQS*WIDTH-1:0]   din,
    output logic [REQS-1:0]         gnt,
    output logic [REQS-1:0]         rvalid,
    output logic [REQS*WIDTH-1:0]   rdata,
    output logic                    mem_we0,
    output logic                    mem_we1,
    output logic [AW-1:0]           mem_addr_write0,
    output logic [AW-1:0]           mem_addr_write1,
    output logic [AW-1:0]           mem_addr_read0,
    output logic [AW-1:0]           mem_addr_read1,
    output logic [WIDTH-1:0]        mem_din0,
    output logic [WIDTH-1:0]        mem_din1,
    input  logic [WIDTH-1:0]        mem_dout0,
    input  logic [WIDTH-1:0]        mem_dout1
);

    localparam logic [PW:0]   REQS_W   = (PW+1)'(REQS);
    localparam logic [PW-1:0] LAST_IDX = PW'(REQS-1);

    logic [AW-1:0]    a_arr [REQS];
    logic [WIDTH-1:0] d_arr [REQS];
    logic [WIDTH-1:0] rd_q  [REQS];

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] last_idx;
    logic          g0_v, g1_v;
    logic [PW-1:0] g0_idx, g1_idx;
    logic [PW:0]   sum;
    logic [PW-1:0] sel;

    logic          p0_v, p1_v;
    logic [PW-1:0] p0_tag, p1_tag;

    for (genvar i = 0; i < REQS; i++) begin : g_lane
        assign a_arr[i] = addr[i*AW +: AW];
        assign d_arr[i] = din[i*WIDTH +: WIDTH];
        assign rdata[i*WIDTH +: WIDTH] = rd_q[i];
    end

    // Scan from ptr; port 1 takes the first later requester that cannot
    // collide with port 0 (same address with a write on either side).
    always_comb begin
        gnt    = '0;
        g0_v   = 1'b0;
        g1_v   = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        sum    = '0;
        sel    = '0;
        for (int k = 0; k < REQS; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= REQS_W) begin
                sum = sum - REQS_W;
            end
            sel = sum[PW-1:0];
            if (rst_n && req[sel]) begin
                if (!g0_v) begin
                    g0_v   = 1'b1;
                    g0_idx = sel;
                end else if (!g1_v && !((a_arr[sel] == a_arr[g0_idx]) && (we[sel] || we[g0_idx]))) begin
                    g1_v   = 1'b1;
                    g1_idx = sel;
                end
            end
        end
        if (g0_v) begin
            gnt[g0_idx] = 1'b1;
        end
        if (g1_v) begin
            gnt[g1_idx] = 1'b1;
        end
    end

    assign last_idx = g1_v ? g1_idx : g0_idx;
    assign ptr_nxt  = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;

    assign mem_we0         = g0_v & we[g0_idx];
    assign mem_addr_write0 = a_arr[g0_idx];
    assign mem_addr_read0  = a_arr[g0_idx];
    assign mem_din0        = d_arr[g0_idx];
    assign mem_we1         = g1_v & we[g1_idx];
    assign mem_addr_write1 = a_arr[g1_idx];
    assign mem_addr_read1  = a_arr[g1_idx];
    assign mem_din1        = d_arr[g1_idx];

    // p*_v/p*_tag cover the BRAM output register stage; rd_q is the return stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            p0_v   <= 1'b0;
            p1_v   <= 1'b0;
            p0_tag <= '0;
            p1_tag <= '0;
            rvalid <= '0;
            for (int i = 0; i < REQS; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            if (g0_v) begin
                ptr <= ptr_nxt;
            end
            p0_v   <= g0_v & ~we[g0_idx];
            p1_v   <= g1_v & ~we[g1_idx];
            p0_tag <= g0_idx;
            p1_tag <= g1_idx;
            rvalid <= '0;
            if (p0_v) begin
                rvalid[p0_tag] <= 1'b1;
                rd_q[p0_tag]   <= mem_dout0;
            end
            if (p1_v) begin
                rvalid[p1_tag] <= 1'b1;
                rd_q[p1_tag]   <= mem_dout1;
            end
        end
    end

endmodule

// File: tb/tb_bram_sqp_arb.sv
// tb/tb_bram_sqp_arb.sv - table-driven bench with read-return scoreboard for bram_sqp_arb
module tb_bram_sqp_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we, gnt, rvalid;
    logic [31:0] addr, din, rdata;
    logic        mem_we0, mem_we1;
    logic [7:0]  mem_addr_write0, mem_addr_write1, mem_addr_read0, mem_addr_read1;
    logic [7:0]  mem_din0, mem_din1;
    logic [7:0]  mem_dout0, mem_dout1;

    bram_sqp_arb #(.REQS(4), .WIDTH(8), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .din(din),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_we0(mem_we0), .mem_we1(mem_we1),
        .mem_addr_write0(mem_addr_write0), .mem_addr_write1(mem_addr_write1),
        .mem_addr_read0(mem_addr_read0), .mem_addr_read1(mem_addr_read1),
        .mem_din0(mem_din0), .mem_din1(mem_din1),
        .mem_dout0(mem_dout0), .mem_dout1(mem_dout1)
    );

    always #5 clk = ~clk;

    logic [7:0] bram [256];
    always @(posedge clk) begin
        if (mem_we0) bram[mem_addr_write0] <= mem_din0;
        if (mem_we1) bram[mem_addr_write1] <= mem_din1;
        mem_dout0 <= bram[mem_addr_read0];
        mem_dout1 <= bram[mem_addr_read1];
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  gnt;
    } vec_t;

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] data;
    } sb_t;

    vec_t       vt [18];
    sb_t        sbq [$];
    logic [7:0] ref_mem [256];
    logic [3:0] exp_rv;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] g);
        vec_t v;
        v.req = r; v.we = w; v.a = a; v.d = d; v.gnt = g;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        req = v.req; we = v.we; addr = v.a; din = v.d;
        @(negedge clk);
        chk(nm, gnt, v.gnt);
        for (int i = 0; i < 4; i++)
            if (v.gnt[i] && v.we[i]) ref_mem[v.a[i*8 +: 8]] = v.d[i*8 +: 8];
        for (int i = 0; i < 4; i++) begin
            if (v.gnt[i] && !v.we[i]) begin
                e.due  = cyc + 2;
                e.idx  = i;
                e.data = ref_mem[v.a[i*8 +: 8]];
                sbq.push_back(e);
            end
        end
    endtask

    // Each cycle: rvalid must match exactly the scoreboard entries due now.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_rv = 4'b0;
            for (int k = sbq.size() - 1; k >= 0; k--) begin
                if (sbq[k].due == cyc) begin
                    exp_rv[sbq[k].idx] = 1'b1;
                    chk($sformatf("rdata%0d@%0d", sbq[k].idx, cyc),
                        rdata[sbq[k].idx*8 +: 8], sbq[k].data);
                    sbq.delete(k);
                end else if (sbq[k].due < cyc) begin
                    chk($sformatf("stale_rd%0d", sbq[k].idx), 1, 0);
                    sbq.delete(k);
                end
            end
            chk($sformatf("rvalid@%0d", cyc), rvalid, exp_rv);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        vt[0]  = mk(4'b0001, 4'b0001, 32'h00000010, 32'h000000A5, 4'b0001);
        vt[1]  = mk(4'b0001, 4'b0000, 32'h00000010, 32'h0,        4'b0001);
        vt[2]  = mk(4'b0000, 4'b0000, 32'h0,        32'h0,        4'b0000);
        vt[3]  = mk(4'b0001, 4'b0001, 32'h00000005, 32'h0000003C, 4'b0001);
        vt[4]  = mk(4'b0110, 4'b0010, 32'h00202000, 32'h00007700, 4'b0010);
        vt[5]  = mk(4'b0100, 4'b0000, 32'h00200000, 32'h0,        4'b0100);
        vt[6]  = mk(4'b1001, 4'b0000, 32'h05000005, 32'h0,        4'b1001);
        vt[7]  = mk(4'b1000, 4'b1000, 32'h30000000, 32'h11000000, 4'b1000);
        vt[8]  = mk(4'b1111, 4'b0000, 32'h30200510, 32'h0,        4'b0011);
        vt[9]  = mk(4'b1111, 4'b0000, 32'h30200510, 32'h0,        4'b1100);
        vt[10] = mk(4'b1111, 4'b0000, 32'h30200510, 32'h0,        4'b0011);
        vt[11] = mk(4'b0001, 4'b0000, 32'h00000010, 32'h0,        4'b0001);
        vt[12] = mk(4'b1111, 4'b0000, 32'h30200510, 32'h0,        4'b0110);
        vt[13] = mk(4'b1111, 4'b0000, 32'h30200510, 32'h0,        4'b1001);
        vt[14] = mk(4'b1110, 4'b0010, 32'h30404000, 32'h00005A00, 4'b1010);
        vt[15] = mk(4'b0100, 4'b0000, 32'h00400000, 32'h0,        4'b0100);
        vt[16] = mk(4'b0011, 4'b0000, 32'h00000510, 32'h0,        4'b0011);
        vt[17] = mk(4'b1111, 4'b0000, 32'h30200510, 32'h0,        4'b0011);

        rst_n = 1'b0; req = 4'b0; we = 4'b0; addr = 32'h0; din = 32'h0;
        repeat (2) @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        chk("reset_gnt", gnt, 4'b0);
        chk("reset_rvalid", rvalid, 4'b0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_mem_we", {mem_we1, mem_we0}, 2'b00);
        req = 4'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 17; i++) apply(vt[i], $sformatf("gnt_v%0d", i));

        // Reads from vt[16] are in flight; a one-cycle reset must swallow them.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = 4'b1111;
        sbq.delete();
        @(negedge clk);
        chk("midreset_gnt", gnt, 4'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b0;
        @(negedge clk);
        chk("postreset_rdata", rdata, 32'h0);
        chk("postreset_rvalid", rvalid, 4'b0);
        apply(vt[17], "gnt_after_reset");

        @(posedge clk);
        #1;
        req = 4'b0;
        repeat (4) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
